// File: rtl/vga_capture_monitor.sv
// TinyVGA PMOD receive monitor: 640x480@60 timing recovery, lock and checks.
// VGA_CAP_SIG_EN builds the per-frame pixel signature; otherwise frame_sig=0.
module vga_capture_monitor (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  vga_in,
  output logic        locked,
  output logic [9:0]  hpos,
  output logic [9:0]  vpos,
  output logic        de,
  output logic [5:0]  pix,
  output logic        frame_done,
  output logic [15:0] frame_sig,
  output logic [7:0]  err_cnt
);

  localparam logic [9:0]  H_TOTAL  = 10'd800;
  localparam logic [9:0]  H_SYNC_X = 10'd656;
  localparam logic [9:0]  H_SYNC_W = 10'd96;
  localparam logic [9:0]  V_TOTAL  = 10'd525;
  localparam logic [9:0]  V_SYNC_Y = 10'd490;
  localparam logic [10:0] V_SYNC_H = 11'd2;
  localparam logic [9:0]  CNT_MAX  = 10'd1023;

  localparam logic [1:0] S_SEARCH = 2'd0;
  localparam logic [1:0] S_TRACK  = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  logic [7:0] r_s1;
  logic       r_hs_d;
  logic       r_vs_d;
  logic [9:0] r_h;
  logic [9:0] r_v;
  logic [9:0] r_hint;
  logic [9:0] r_vint;
  logic       r_harm;
  logic       r_varm;
  logic [1:0] r_state;
  logic [1:0] r_good;
  logic       r_locked;
  logic       r_de;
  logic [5:0] r_pix;
  logic       r_fdone;
  logic [7:0] r_err_cnt;

  logic        w_hfall, w_hrise, w_vfall, w_vrise;
  logic        w_hwrap;
  logic [9:0]  w_x, w_y;
  logic [10:0] w_vcnt;
  logic        w_err;
  logic        w_act;
  logic        w_lock_n;
  logic [5:0]  w_col;
  logic [1:0]  w_state_n;
  logic [1:0]  w_good_n;

  assign w_hfall = r_hs_d & ~r_s1[7];
  assign w_hrise = ~r_hs_d & r_s1[7];
  assign w_vfall = r_vs_d & ~r_s1[3];
  assign w_vrise = ~r_vs_d & r_s1[3];

  // w_x/w_y are the coordinates of the sample now held in r_s1
  assign w_hwrap = ~w_hfall & (r_h == H_TOTAL - 10'd1);
  assign w_x = w_hfall ? H_SYNC_X :
               w_hwrap ? 10'd0 : r_h + 10'd1;
  assign w_y = w_vfall ? V_SYNC_Y :
               !w_hwrap ? r_v :
               (r_v == V_TOTAL - 10'd1) ? 10'd0 : r_v + 10'd1;

  assign w_vcnt = {1'b0, r_vint} + {10'd0, w_hwrap};

  assign w_err = (r_harm & w_hfall & (r_hint != H_TOTAL))
               | (r_harm & w_hrise & (r_hint != H_SYNC_W))
               | (r_harm & (r_hint == CNT_MAX))
               | (r_varm & w_vfall & (w_vcnt != {1'b0, V_TOTAL}))
               | (r_varm & w_vrise & (w_vcnt != V_SYNC_H));

  assign w_act = (w_x < 10'd640) && (w_y < 10'd480);
  assign w_col = {r_s1[0], r_s1[4], r_s1[1],
                  r_s1[5], r_s1[2], r_s1[6]};

  always_comb begin
    w_state_n = r_state;
    w_good_n  = r_good;
    if (w_err) begin
      w_state_n = S_SEARCH;
      w_good_n  = 2'd0;
    end else begin
      unique case (r_state)
        S_SEARCH: if (w_vfall) begin
          w_state_n = S_TRACK;
          w_good_n  = 2'd0;
        end
        S_TRACK: if (w_vfall) begin
          w_good_n = r_good + 2'd1;
          if (r_good == 2'd1) w_state_n = S_LOCKED;
        end
        S_LOCKED: ;
        default: w_state_n = S_SEARCH;
      endcase
    end
  end

  assign w_lock_n = (w_state_n == S_LOCKED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1      <= 8'h88;
      r_hs_d    <= 1'b1;
      r_vs_d    <= 1'b1;
      r_h       <= 10'd0;
      r_v       <= 10'd0;
      r_hint    <= 10'd0;
      r_vint    <= 10'd0;
      r_harm    <= 1'b0;
      r_varm    <= 1'b0;
      r_state   <= S_SEARCH;
      r_good    <= 2'd0;
      r_locked  <= 1'b0;
      r_de      <= 1'b0;
      r_pix     <= 6'd0;
      r_fdone   <= 1'b0;
      r_err_cnt <= 8'd0;
    end else begin
      r_s1   <= vga_in;
      r_hs_d <= r_s1[7];
      r_vs_d <= r_s1[3];
      r_h    <= w_x;
      r_v    <= w_y;
      if (w_hfall)
        r_hint <= 10'd1;
      else if (r_hint != CNT_MAX)
        r_hint <= r_hint + 10'd1;
      if (w_vfall)
        r_vint <= 10'd0;
      else if (w_hwrap && r_vint != CNT_MAX)
        r_vint <= r_vint + 10'd1;
      // an error disarms; only a later clean edge re-arms
      r_harm   <= ~w_err & (r_harm | w_hfall);
      r_varm   <= ~w_err & (r_varm | w_vfall);
      r_state  <= w_state_n;
      r_good   <= w_good_n;
      r_locked <= w_lock_n;
      r_de     <= w_lock_n & w_act;
      r_pix    <= (w_lock_n & w_act) ? w_col : 6'd0;
      r_fdone  <= w_vfall & (r_state == S_LOCKED) & ~w_err;
      if (w_err && r_err_cnt != 8'hFF)
        r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

`ifdef VGA_CAP_SIG_EN
  logic [15:0] r_acc;
  logic [15:0] r_sig;
  logic [15:0] w_add;

  assign w_add = w_act ? {10'd0, w_col} : 16'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= 16'd0;
      r_sig <= 16'd0;
    end else if (w_vfall) begin
      r_sig <= r_acc;
      r_acc <= w_add;
    end else begin
      r_acc <= r_acc + w_add;
    end
  end

  assign frame_sig = r_sig;
`else
  assign frame_sig = 16'd0;
`endif

  assign locked     = r_locked;
  assign hpos       = r_h;
  assign vpos       = r_v;
  assign de         = r_de;
  assign pix        = r_pix;
  assign frame_done = r_fdone;
  assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_vga_capture_monitor.sv
// Directed bench for vga_capture_monitor: a behavioural 640x480 source
// with injected sync faults; outputs checked two clocks behind the pins.
module tb_vga_capture_monitor;

`ifdef VGA_CAP_SIG_EN
  localparam logic [15:0] SIG_W = 16'h5000;
  localparam logic [15:0] SIG_C = 16'h7000;
`else
  localparam logic [15:0] SIG_W = 16'h0000;
  localparam logic [15:0] SIG_C = 16'h0000;
`endif

  logic        clk;
  logic        rst_n;
  logic [7:0]  vga_in;
  logic        locked;
  logic [9:0]  hpos;
  logic [9:0]  vpos;
  logic        de;
  logic [5:0]  pix;
  logic        frame_done;
  logic [15:0] frame_sig;
  logic [7:0]  err_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int de_cnt = 0;
  int fd_cnt = 0;

  int gx, gy, lx, ly;
  int g_hs_end;
  logic g_hs_off;
  logic g_vs_late;
  logic [5:0] g_col;

  vga_capture_monitor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vga_in     (vga_in),
    .locked     (locked),
    .hpos       (hpos),
    .vpos       (vpos),
    .de         (de),
    .pix        (pix),
    .frame_done (frame_done),
    .frame_sig  (frame_sig),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic hs, input logic vs,
                      input logic [5:0] c);
    @(negedge clk);
    if (de === 1'b1) de_cnt++;
    if (frame_done === 1'b1) fd_cnt++;
    vga_in = {hs, c[0], c[2], c[4], vs, c[1], c[3], c[5]};
  endtask

  task automatic std_clk();
    logic hs, vs;
    logic [5:0] c;
    hs = !(gx >= 656 && gx < g_hs_end) || g_hs_off;
    vs = !(gy >= 490 && gy < 492) ||
         (g_vs_late && gy == 490 && gx < 656);
    c  = (gx < 640 && gy < 480) ? g_col : 6'd0;
    tick(hs, vs, c);
    lx = gx;
    ly = gy;
    gx++;
    if (gx == 800) begin
      gx = 0;
      gy++;
      if (gy == 525) gy = 0;
    end
  endtask

  task automatic run_until(input int ty, input int tx);
    do std_clk();
    while (!(ly == ty && lx == tx));
  endtask

  initial begin
    rst_n = 1'b0;
    vga_in = 8'h88;
    gx = 0; gy = 489; lx = 0; ly = 0;
    g_hs_end = 752; g_hs_off = 1'b0;
    g_vs_late = 1'b0; g_col = 6'd0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_locked", locked, 0);
    check("rst_hpos", hpos, 0);
    check("rst_vpos", vpos, 0);
    check("rst_de", de, 0);
    check("rst_pix", pix, 0);
    check("rst_fdone", frame_done, 0);
    check("rst_sig", frame_sig, 0);
    check("rst_err", err_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // vsync fall 1, then a black frame up to fall 2
    run_until(490, 0);
    run_until(490, 0);
    g_col = 6'd63;
    repeat (2) std_clk();
    check("black_sig", frame_sig, 16'h0000);
    check("trk_locked", locked, 0);
    check("trk_err", err_cnt, 0);
    check("trk_fd", fd_cnt, 0);

    // fall 3: lock two clocks after
    run_until(490, 0);
    check("lock_m0", locked, 0);
    std_clk();
    check("lock_m1", locked, 0);
    std_clk();
    check("lock_p2", locked, 1);
    check("white_sig1", frame_sig, SIG_W);
    check("no_fd_at_lock", fd_cnt, 0);

    run_until(10, 639);
    repeat (2) std_clk();
    check("hpos_639", hpos, 639);
    check("vpos_10", vpos, 10);
    check("de_639", de, 1);
    check("pix_639", pix, 63);
    std_clk();
    check("de_640", de, 0);
    check("pix_640", pix, 0);

    run_until(20, 0);
    de_cnt = 0;
    repeat (800) std_clk();
    check("de_per_line", de_cnt, 640);

    // fall 4: clean frame while locked
    run_until(490, 0);
    g_col = 6'd21;
    repeat (2) std_clk();
    check("fdone_pulse", frame_done, 1);
    check("white_sig2", frame_sig, SIG_W);
    std_clk();
    check("fdone_once", frame_done, 0);
    check("fd_cnt1", fd_cnt, 1);

    // 95-clock hsync pulse
    run_until(491, 0);
    g_hs_end = 751;
    run_until(491, 751);
    g_hs_end = 752;
    check("short_m0", locked, 1);
    std_clk();
    check("short_m1", locked, 1);
    std_clk();
    check("short_lock", locked, 0);
    check("short_err", err_cnt, 1);

    // hsync stops after a clean reference fall
    run_until(492, 760);
    g_hs_off = 1'b1;
    run_until(494, 79);
    std_clk();
    check("to_m1", err_cnt, 1);
    std_clk();
    check("to_err", err_cnt, 2);
    run_until(496, 0);
    g_hs_off = 1'b0;
    check("to_once", err_cnt, 2);

    run_until(100, 100);
    repeat (2) std_clk();
    check("unl_hpos", hpos, 100);
    check("unl_vpos", vpos, 100);
    check("unl_de", de, 0);
    check("unl_pix", pix, 0);

    // 801-clock line ending on the vsync fall
    run_until(489, 799);
    tick(1'b1, 1'b1, 6'd0);
    g_vs_late = 1'b1;
    run_until(490, 656);
    g_vs_late = 1'b0;
    std_clk();
    check("str_m1", err_cnt, 2);
    std_clk();
    check("str_err", err_cnt, 3);
    check("str_sig", frame_sig, SIG_C);
    check("str_fd", fd_cnt, 1);
    check("str_locked", locked, 0);

    // asynchronous reset mid-frame
    run_until(495, 300);
    rst_n = 1'b0;
    #1;
    check("ar_err", err_cnt, 0);
    check("ar_sig", frame_sig, 0);
    check("ar_hpos", hpos, 0);
    check("ar_vpos", vpos, 0);
    check("ar_locked", locked, 0);
    check("ar_de", de, 0);
    check("ar_pix", pix, 0);
    check("ar_fdone", frame_done, 0);
    repeat (3) std_clk();
    rst_n = 1'b1;
    run_until(497, 200);
    repeat (2) std_clk();
    check("post_hpos", hpos, 200);
    check("post_locked", locked, 0);
    check("post_err", err_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_capture_monitor.md
# vga_capture_monitor

Receive-side counterpart of the TinyVGA PMOD output: samples the 8-bit PMOD bus {hsync, B0, G0, R0, vsync, B1, G1, R1}, recovers 640x480@60 timing (800x525 total, negative syncs), and regenerates pixel coordinates and decoded 6-bit colour. It also checks sync timing, reports lock, and produces a per-frame pixel signature. It sits in loopback and test harnesses, clocked from the same 25.175 MHz pixel clock as the generator.

## Interface
- No parameters; timing constants are fixed: H_TOTAL 800, H_SYNC_X 656, H_SYNC_W 96, V_TOTAL 525, V_SYNC_Y 490, V_SYNC_H 2.
- clk  in  1  pixel clock
- rst_n  in  1  reset, asynchronous, active-low
- vga_in  in  8  PMOD bus: [7] hsync, [6] B0, [5] G0, [4] R0, [3] vsync, [2] B1, [1] G1, [0] R1
- locked  out  1  timing locked
- hpos  out  10  recovered x, 0..799
- vpos  out  10  recovered y, 0..524
- de  out  1  locked && hpos<640 && vpos<480
- pix  out  6  {R1,R0,G1,G0,B1,B0} when de, else 0
- frame_done  out  1  one-cycle pulse, clean frame completed while LOCKED
- frame_sig  out  16  signature of last completed frame
- err_cnt  out  8  saturating timing-error count

## Operation
- Input stage: vga_in is registered once (s1), plus a delayed copy of the s1 syncs for edge detection. No metastability synchroniser; same clock domain.
- Horizontal: an hsync falling edge in s1 means the s1 sample is x=656. The h counter is loaded to 656 and otherwise increments, wrapping 799->0.
- Vertical: the v counter increments on each h wrap, 524->0. A vsync falling edge in s1 loads 490.
- Interval checks, armed only after a reference edge since the last SEARCH entry:
  - hsync fall-to-fall must be 800 clocks; hsync low width must be 96 clocks.
  - vsync fall-to-fall must be 525 h-wraps; vsync low width must be 2 lines.
- Timeout: the 10-bit hsync interval counter saturates at 1023. Reaching 1023 is an error.
- Error handling: any failed check in a cycle increments err_cnt by exactly 1 (saturating at 255) and forces the FSM to SEARCH.
- FSM:
  - SEARCH: locked=0. The first vsync fall moves to TRACK and clears good=0.
  - TRACK: each vsync fall with no error since the previous one sets good++. When good reaches 2, move to LOCKED.
  - LOCKED: locked=1. Any error moves to SEARCH.
- Signature: a 16-bit wrapping sum of the 6-bit pix value over all cycles where the recovered position is active (hpos<640, vpos<480). It accumulates in all states.
  - At each vsync fall the accumulator is transferred to frame_sig and cleared.
  - frame_done pulses on that vsync fall only when the FSM is already LOCKED and no error occurs that cycle.
- Simultaneous error and vsync fall: the error wins. There is no frame_done and no good increment, but frame_sig still updates.

## Timing
- Outputs hpos, vpos, de, pix, locked, frame_done are registered. They describe the pin sample taken 2 clocks earlier.
- Reset values: locked=0, hpos=0, vpos=0, de=0, pix=0, frame_done=0, frame_sig=0, err_cnt=0. FSM=SEARCH, good=0, checks disarmed.
- From a clean source starting at frame start, locked rises 2 clocks after the third vsync fall reaches the pins.
- locked falls 2 clocks after the offending pin sample.
- Reset mid-frame returns all state to reset values immediately; re-lock requires 3 further vsync falls.

## Configuration
- VGA_CAP_SIG_EN defined: the signature accumulator and frame_sig logic are built as described.
- VGA_CAP_SIG_EN undefined: there is no accumulator, and frame_sig is tied to 0. frame_done behaviour is unchanged.

## Test plan
- Clean generator, solid black -> locked=1 after the 3rd vsync fall; err_cnt=0; frame_done once per 420000 clocks; frame_sig=0x0000.
- Clean generator, solid white (pix=63) -> frame_sig=0x5000 (63*307200 mod 65536) on every frame_done; de high for 640 clocks per active line.
- Clean lock, then one hsync pulse of 95 clocks -> err_cnt=1, locked=0 two clocks later; re-lock after 3 clean vsync falls.
- Stop hsync (held high) while LOCKED -> error at interval 1023; err_cnt increments once; locked=0.
- Line stretched to 801 clocks on the same cycle as the vsync fall -> err_cnt+1, no frame_done, FSM=SEARCH.
- Assert rst_n=0 mid-frame while LOCKED -> all outputs 0 asynchronously; after release, locked=0 until 3 clean vsync falls.
